rx_word_aligner: RTL
====================

# rx_word_aligner

Receive-side serial-to-word aligner for the SerDes link. It takes the recovered serial bitstream (the far end of the PISO serializer), finds 10-bit word boundaries by hunting for K28.5 commas, and emits aligned 10-bit code groups to the 10b/8b decoder. A HUNT/SYNC/LOCKED state machine qualifies alignment before `locked` asserts, and it drops lock after repeated misaligned commas.

## Interface
Parameters:
- `LOCK_COUNT`, 3: consecutive aligned commas required to assert `locked` (≥1).
- `LOSS_COUNT`, 4: misaligned commas seen while LOCKED that force a return to HUNT (≥1).

Ports:
- `clk`  input  1  single system clock; all logic on posedge.
- `rst`  input  1  asynchronous, active-high reset.
- `ser_in`  input  1  serial bit; valid only when `ser_valid`=1.
- `ser_valid`  input  1  bit strobe; one bit consumed per cycle when high.
- `word_out`  output  10  aligned code group; first received bit in `word_out[0]`.
- `word_valid`  output  1  one-cycle pulse; `word_out` holds a new word.
- `is_comma`  output  1  qualifies `word_out` as K28.5; valid with `word_valid`.
- `locked`  output  1  alignment qualified; level.

## Operation
- Shift: on `ser_valid`, `win <= {ser_in, win[9:1]}`, so bits arrive LSB-first. Comma detect is combinational on the post-shift value `nwin`. A comma is `nwin == 10'h17C` (K28.5 RD−) or `nwin == 10'h283` (K28.5 RD+).
- `bit_cnt` counts 0..9 and marks a boundary when it equals 9 on a strobe. It wraps to 0.
- Counters: `comma_cnt` has width `$clog2(LOCK_COUNT+1)`; `err_cnt` has width `$clog2(LOSS_COUNT+1)`. Both saturate and never wrap.
- The states below act only on a cycle with `ser_valid`=1. They persist otherwise.
- **HUNT**: on a comma, emit `nwin` as a word with `is_comma`=1 and set `bit_cnt`=0.
  - If `LOCK_COUNT`==1, go to LOCKED with `locked`=1.
  - Otherwise set `comma_cnt`=1 and go to SYNC.
  - No words are emitted in HUNT except the comma itself.
- **SYNC**: at a boundary, emit `nwin` with `is_comma` set to the comma flag.
  - On an aligned comma, increment `comma_cnt`. On reaching `LOCK_COUNT`, go to LOCKED and assert `locked`.
  - A non-comma word at a boundary does not reset `comma_cnt`.
  - A comma at a non-boundary realigns: emit it as a comma word, set `bit_cnt`=0, `comma_cnt`=1, and stay in SYNC.
- **LOCKED**: emit a word at every boundary.
  - An aligned comma clears `err_cnt`.
  - A misaligned comma increments `err_cnt` and emits no word.
  - When `err_cnt` reaches `LOSS_COUNT`, go to HUNT, clear both counters and `locked`. The comma that reached the limit is not emitted.
- Simultaneous events: a misaligned comma that lands on a cycle where another rule would apply takes priority over the boundary word. This cannot occur at a boundary by definition.

## Timing
- Reset: `rst` high immediately (asynchronously) forces `word_out`=0, `word_valid`=0, `is_comma`=0, `locked`=0, state HUNT, `win`=0, and all counters 0. First action is on the first posedge after `rst` falls.
- Word latency: `word_valid`, `word_out` and `is_comma` are registered. They appear in the cycle after the posedge that shifted in the 10th bit.
- `word_valid` is high for exactly one cycle per word and is low on any cycle whose preceding posedge had `ser_valid`=0.
- `locked` rises in the same cycle as the `word_valid` of the `LOCK_COUNT`-th aligned comma. It falls in the cycle after the posedge that consumed the `LOSS_COUNT`-th misaligned comma's last bit.
- Gaps in `ser_valid` stretch timing but never change the word sequence.
- Throughput: at most one word per 10 strobes. The minimum `word_valid` spacing is 10 cycles.

## Test plan
- **Reset mid-stream**: assert `rst` asynchronously between edges while LOCKED. All outputs go to 0 before the next posedge. After release, random non-comma bits produce no `word_valid`.
- **Lock acquisition** (`LOCK_COUNT`=3): send 7 random bits, then 17C, 283, 17C, 2AA.
  - `word_valid` with 17C and `is_comma`=1 appears one cycle after its 10th bit.
  - `locked`=1 arrives with the third comma word.
  - 2AA then follows with `is_comma`=0.
- **Strobe gaps**: same stream with `ser_valid` randomly 50% duty gives an identical word/`is_comma`/`locked` sequence.
- **Loss of lock** (`LOSS_COUNT`=4): while LOCKED, drop one bit, then send 17C repeatedly.
  - The first 3 misaligned commas leave `locked`=1 and emit no words.
  - `locked` clears after the 4th.
  - The next comma is emitted from HUNT and realignment proceeds.
- **SYNC realign**: send one aligned comma, then a one-bit slip and commas. The word `word_out`=17C is emitted at the new phase. `locked` needs 3 commas counted from the realign.
- **LOCK_COUNT=1**: the first detected comma asserts `locked` in the same cycle as its `word_valid`.

Source files
------------

// File: rtl/rx_word_aligner.sv
// rx_word_aligner: recovers 10-bit code-group boundaries from the serial
// bitstream by hunting for K28.5 commas. It qualifies the alignment through
// HUNT/SYNC/LOCKED before asserting `locked`, and returns to HUNT after
// repeated misaligned commas. Words leave LSB-first-received in bit 0.
module rx_word_aligner #(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_in,
  input  logic       ser_valid,
  output logic [9:0] word_out,
  output logic       word_valid,
  output logic       is_comma,
  output logic       locked
);

  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int EW = $clog2(LOSS_COUNT + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_COUNT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [EW-1:0] LOSS_LIM = EW'(LOSS_COUNT);
  localparam logic [EW-1:0] ERR_ONE  = EW'(1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // K28.5 in either running disparity
  function automatic logic is_k28_5(input logic [9:0] w);
    return (w == 10'h17C) || (w == 10'h283);
  endfunction

  state_t          state_r, state_nxt_s;
  logic [9:0]      win_r, win_nxt_s;
  logic [3:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [CW-1:0]   comma_cnt_r, comma_cnt_nxt_s, comma_cnt_inc_s;
  logic [EW-1:0]   err_cnt_r, err_cnt_nxt_s, err_cnt_inc_s;
  logic [9:0]      word_out_r, word_out_nxt_s;
  logic            word_valid_r, word_valid_nxt_s;
  logic            is_comma_r, is_comma_nxt_s;
  logic            locked_r, locked_nxt_s;
  logic [9:0]      nwin_s;
  logic            comma_s;
  logic            boundary_s;

  // Detection works on the window as it will look after this strobe's shift
  assign nwin_s     = {ser_in, win_r[9:1]};
  assign comma_s    = is_k28_5(nwin_s);
  assign boundary_s = (bit_cnt_r == 4'd9);

  // Saturating increments; counters never wrap past their limits
  assign comma_cnt_inc_s = (comma_cnt_r == LOCK_LIM) ? comma_cnt_r : comma_cnt_r + CNT_ONE;
  assign err_cnt_inc_s   = (err_cnt_r == LOSS_LIM) ? err_cnt_r : err_cnt_r + ERR_ONE;

  assign word_out   = word_out_r;
  assign word_valid = word_valid_r;
  assign is_comma   = is_comma_r;
  assign locked     = locked_r;

  // State, shift window, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_HUNT;
      win_r        <= 10'd0;
      bit_cnt_r    <= 4'd0;
      comma_cnt_r  <= '0;
      err_cnt_r    <= '0;
      word_out_r   <= 10'd0;
      word_valid_r <= 1'b0;
      is_comma_r   <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      win_r        <= win_nxt_s;
      bit_cnt_r    <= bit_cnt_nxt_s;
      comma_cnt_r  <= comma_cnt_nxt_s;
      err_cnt_r    <= err_cnt_nxt_s;
      word_out_r   <= word_out_nxt_s;
      word_valid_r <= word_valid_nxt_s;
      is_comma_r   <= is_comma_nxt_s;
      locked_r     <= locked_nxt_s;
    end
  end

  // Next-state and output decode; nothing advances without a bit strobe
  always_comb begin
    state_nxt_s      = state_r;
    win_nxt_s        = win_r;
    bit_cnt_nxt_s    = bit_cnt_r;
    comma_cnt_nxt_s  = comma_cnt_r;
    err_cnt_nxt_s    = err_cnt_r;
    word_out_nxt_s   = word_out_r;
    word_valid_nxt_s = 1'b0;
    is_comma_nxt_s   = is_comma_r;
    locked_nxt_s     = locked_r;
    if (ser_valid) begin
      win_nxt_s = nwin_s;
      if (boundary_s) begin
        bit_cnt_nxt_s = 4'd0;
      end else begin
        bit_cnt_nxt_s = bit_cnt_r + 4'd1;
      end
      case (state_r)
        ST_HUNT: begin
          if (comma_s) begin
            word_out_nxt_s   = nwin_s;
            word_valid_nxt_s = 1'b1;
            is_comma_nxt_s   = 1'b1;
            bit_cnt_nxt_s    = 4'd0;
            if (LOCK_COUNT == 1) begin
              state_nxt_s  = ST_LOCKED;
              locked_nxt_s = 1'b1;
            end else begin
              comma_cnt_nxt_s = CNT_ONE;
              state_nxt_s     = ST_SYNC;
            end
          end else begin
            state_nxt_s = ST_HUNT;
          end
        end
        ST_SYNC: begin
          if (comma_s && !boundary_s) begin
            // Comma at a new phase: restart qualification from here
            word_out_nxt_s   = nwin_s;
            word_valid_nxt_s = 1'b1;
            is_comma_nxt_s   = 1'b1;
            bit_cnt_nxt_s    = 4'd0;
            comma_cnt_nxt_s  = CNT_ONE;
          end else if (boundary_s) begin
            word_out_nxt_s   = nwin_s;
            word_valid_nxt_s = 1'b1;
            is_comma_nxt_s   = comma_s;
            if (comma_s) begin
              comma_cnt_nxt_s = comma_cnt_inc_s;
              if (comma_cnt_inc_s == LOCK_LIM) begin
                state_nxt_s  = ST_LOCKED;
                locked_nxt_s = 1'b1;
              end else begin
                state_nxt_s = ST_SYNC;
              end
            end else begin
              comma_cnt_nxt_s = comma_cnt_r;
            end
          end else begin
            state_nxt_s = ST_SYNC;
          end
        end
        ST_LOCKED: begin
          if (comma_s && !boundary_s) begin
            // Misaligned comma is counted, never emitted
            if (err_cnt_inc_s == LOSS_LIM) begin
              state_nxt_s     = ST_HUNT;
              comma_cnt_nxt_s = '0;
              err_cnt_nxt_s   = '0;
              locked_nxt_s    = 1'b0;
            end else begin
              err_cnt_nxt_s = err_cnt_inc_s;
            end
          end else if (boundary_s) begin
            word_out_nxt_s   = nwin_s;
            word_valid_nxt_s = 1'b1;
            is_comma_nxt_s   = comma_s;
            if (comma_s) begin
              err_cnt_nxt_s = '0;
            end else begin
              err_cnt_nxt_s = err_cnt_r;
            end
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default: begin
          state_nxt_s     = ST_HUNT;
          comma_cnt_nxt_s = '0;
          err_cnt_nxt_s   = '0;
          locked_nxt_s    = 1'b0;
        end
      endcase
    end else begin
      word_valid_nxt_s = 1'b0;
    end
  end

endmodule
